// File: rtl/display_scheduler_pkg.sv
// Shared definitions for the display scheduler: FSM encoding, conversion sizing
// and the round-robin index helper.
package display_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    localparam int CONV_STEPS = 8;
    localparam int DIGIT_W    = 4;
    localparam int BIN_W      = 8;
    localparam int NUM_DIGITS = 3;
    localparam int DD_W       = NUM_DIGITS * DIGIT_W + BIN_W;
    localparam int STEP_W     = $clog2(CONV_STEPS);

    // (base + step) mod n, valid for base < n and step <= n
    function automatic logic [1:0] rr_next(input logic [1:0] base,
                                           input int unsigned step,
                                           input int unsigned n);
        int unsigned s;
        s = 32'(base) + step;
        if (s >= n) begin
            s = s - n;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/bcd_shift_step.sv
// One combinational double-dabble iteration on the {BCD, binary} register:
// add 3 to every BCD nibble >= 5, then shift the whole register left by one.
module bcd_shift_step
    import display_scheduler_pkg::*;
(
    input  logic [DD_W-1:0] d_i,
    output logic [DD_W-1:0] q_o
);

    logic [DD_W-1:0] adj;

    assign adj[BIN_W-1:0] = d_i[BIN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            localparam int LSB = BIN_W + gi * DIGIT_W;
            assign adj[LSB +: DIGIT_W] = (d_i[LSB +: DIGIT_W] >= DIGIT_W'(5))
                                       ? d_i[LSB +: DIGIT_W] + DIGIT_W'(3)
                                       : d_i[LSB +: DIGIT_W];
        end
    endgenerate

    assign q_o = {adj[DD_W-2:0], 1'b0};

endmodule

// File: rtl/display_7_seg.sv
// BCD digit to active-low segment pattern {g,f,e,d,c,b,a}; non-decimal codes blank.
module display_7_seg (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (digit_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/display_scheduler.sv
// Shares the 3-digit 7-segment display between NUM_SRC observation taps:
// round-robin arbitration, serial binary-to-BCD conversion, then a fixed dwell.
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_SRC-1:0]   src_value,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic                   mode_auto,
    output logic [NUM_SRC-1:0]     src_grant,
    output logic [1:0]             src_sel,
    output logic                   busy,
    output logic [20:0]            saida
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CONV_STEPS - 1);

    state_t                                state_q, state_d;
    logic [NUM_SRC-1:0]                    pend_q, pend_d;
    logic [NUM_SRC-1:0]                    grant_q, grant_d;
    logic [1:0]                            rr_q, rr_d;
    logic [1:0]                            sel_q, sel_d;
    logic                                  busy_q, busy_d;
    logic [DD_W-1:0]                       dd_q, dd_d;
    logic [STEP_W-1:0]                     step_q, step_d;
    logic [HOLD_W-1:0]                     hold_q, hold_d;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]    digit_q, digit_d;

    logic [DD_W-1:0] dd_step;
    logic            arb_found;
    logic [1:0]      arb_idx;
    logic [1:0]      win_idx;

    bcd_shift_step u_step (
        .d_i (dd_q),
        .q_o (dd_step)
    );

    // First pending source after the last one shown wins
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!arb_found && pend_q[rr_next(rr_q, k, NUM_SRC)]) begin
                arb_found = 1'b1;
                arb_idx   = rr_next(rr_q, k, NUM_SRC);
            end
        end
        win_idx = arb_found ? arb_idx : rr_next(rr_q, 1, NUM_SRC);
    end

    always_comb begin
        state_d = state_q;
        grant_d = '0;
        rr_d    = rr_q;
        sel_d   = sel_q;
        dd_d    = dd_q;
        step_d  = step_q;
        hold_d  = hold_q;
        digit_d = digit_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found || mode_auto) begin
                    if (arb_found) begin
                        grant_d[win_idx] = 1'b1;
                    end
                    dd_d    = {{(DD_W-BIN_W){1'b0}}, src_value[{win_idx, 3'b000} +: BIN_W]};
                    rr_d    = win_idx;
                    sel_d   = win_idx;
                    step_d  = '0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                dd_d   = dd_step;
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_LAST) begin
                    digit_d = dd_step[DD_W-1:BIN_W];
                    hold_d  = '0;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A request on the grant edge re-arms the bit it just cleared
        pend_d = (pend_q & ~grant_d) | src_req;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            rr_q    <= 2'(NUM_SRC - 1);
            sel_q   <= '0;
            busy_q  <= 1'b0;
            dd_q    <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            dd_q    <= dd_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            digit_q <= digit_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
            display_7_seg u_seg (
                .digit_i (digit_q[gi]),
                .seg_o   (saida[7*gi +: 7])
            );
        end
    endgenerate

    assign src_grant = grant_q;
    assign src_sel   = sel_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: a transaction-level model (countdown of busy
// cycles, decimal digits by division) checked every cycle, plus directed literals.
module tb_display_scheduler;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int SPACING = 1 + 8 + HOLD;

    localparam logic [20:0] P000 = 21'b1000000_1000000_1000000;
    localparam logic [20:0] P137 = 21'b1111001_0110000_1111000;
    localparam logic [20:0] P099 = 21'b1000000_0010000_0010000;
    localparam logic [20:0] P200 = 21'b0100100_1000000_1000000;
    localparam logic [20:0] P255 = 21'b0100100_0010010_0010010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [8*N-1:0] src_value = '0;
    logic [N-1:0]  src_req = '0;
    logic          mode_auto = 1'b0;
    logic [N-1:0]  src_grant;
    logic [1:0]    src_sel;
    logic          busy;
    logic [20:0]   saida;

    display_scheduler #(.NUM_SRC(N), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_value (src_value),
        .src_req   (src_req),
        .mode_auto (mode_auto),
        .src_grant (src_grant),
        .src_sel   (src_sel),
        .busy      (busy),
        .saida     (saida)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [20:0] show_pat(input int v);
        return {seg7(v / 100), seg7((v / 10) % 10), seg7(v % 10)};
    endfunction

    // Behavioural model: a grant/auto pick starts 8+HOLD busy cycles; the
    // decimal value appears once the 8 conversion cycles have elapsed.
    logic [N-1:0] m_pend;
    logic [N-1:0] m_grant;
    logic [20:0]  m_saida;
    int m_rr, m_rem, m_val, m_sel, m_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = '0;
            m_grant = '0;
            m_rr    = N - 1;
            m_rem   = 0;
            m_val   = 0;
            m_sel   = 0;
            m_saida = show_pat(0);
        end else begin
            m_grant = '0;
            if (m_rem == 0) begin
                m_w = -1;
                for (int k = 1; k <= N; k++)
                    if (m_w < 0 && m_pend[(m_rr + k) % N]) m_w = (m_rr + k) % N;
                if (m_w >= 0) begin
                    m_grant[m_w] = 1'b1;
                    m_pend[m_w]  = 1'b0;
                end else if (mode_auto) begin
                    m_w = (m_rr + 1) % N;
                end
                if (m_w >= 0) begin
                    m_val = int'(src_value[8*m_w +: 8]);
                    m_rr  = m_w;
                    m_sel = m_w;
                    m_rem = 8 + HOLD;
                end
            end else begin
                m_rem--;
                if (m_rem == HOLD) m_saida = show_pat(m_val);
            end
            m_pend = m_pend | src_req;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("grant", 32'(src_grant), 32'(m_grant));
            check("sel",   32'(src_sel),   32'(m_sel));
            check("busy",  32'(busy),      32'(m_rem != 0));
            check("saida", 32'(saida),     32'(m_saida));
        end
    end

    task automatic wait_grant(input int budget, output int at, output logic [N-1:0] vec);
        bit got = 0;
        at  = -1;
        vec = '0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (src_grant != '0) begin
                got = 1;
                at  = cyc;
                vec = src_grant;
            end
        end
        if (!got) check("grant_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_busy_rise(input int budget, output int at);
        bit got = 0;
        logic prev;
        prev = busy;
        at = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (busy && !prev) begin
                got = 1;
                at  = cyc;
            end
            prev = busy;
        end
        if (!got) check("busy_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        src_req = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    int at, prev_at, r0, busy_cnt;
    logic [N-1:0] vec;

    initial begin
        logic [20:0] pats [4];
        pats[0] = P000; pats[1] = P099; pats[2] = P200; pats[3] = P255;

        // Reset state
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check("rst_sel",   32'(src_sel),   32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_grant", 32'(src_grant), 32'(0));
        check("rst_saida", 32'(saida),     32'(P000));

        // Single request: src2 = 137
        @(negedge clk);
        src_value = {8'd0, 8'd137, 8'd0, 8'd0};
        src_req   = 4'b0100;
        r0 = cyc;
        @(negedge clk);
        src_req = '0;
        wait_grant(5, at, vec);
        check("single_grant", 32'(vec), 32'(4'b0100));
        check("single_lat",   32'(at - r0), 32'(2));
        check("single_sel",   32'(src_sel), 32'(2));
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (i == 7) check("single_old", 32'(saida), 32'(P000));
            if (i == 8) check("single_137", 32'(saida), 32'(P137));
            if (busy) busy_cnt++;
            else break;
        end
        check("single_busy_len", 32'(busy_cnt), 32'(12));

        // Simultaneous requests after reset
        do_reset();
        @(negedge clk);
        src_value = {8'd255, 8'd200, 8'd99, 8'd0};
        src_req   = 4'b1111;
        @(negedge clk);
        src_req = '0;
        prev_at = 0;
        for (int j = 0; j < 4; j++) begin
            wait_grant(40, at, vec);
            check("simul_grant", 32'(vec), 32'(4'b0001 << j));
            if (j > 0) check("simul_spacing", 32'(at - prev_at), 32'(SPACING));
            prev_at = at;
            repeat (8) @(negedge clk);
            check("simul_digits", 32'(saida), 32'(pats[j]));
        end

        // Request during SHOW: src1 waits for src3's dwell to end
        do_reset();
        @(negedge clk);
        src_value = {8'd77, 8'd0, 8'd11, 8'd0};
        src_req   = 4'b1000;
        @(negedge clk);
        src_req = '0;
        wait_grant(5, at, vec);
        check("show_first", 32'(vec), 32'(4'b1000));
        prev_at = at;
        repeat (9) @(negedge clk);
        src_req = 4'b0010;
        @(negedge clk);
        src_req = '0;
        wait_grant(40, at, vec);
        check("show_second", 32'(vec), 32'(4'b0010));
        check("show_spacing", 32'(at - prev_at), 32'(SPACING));

        // Grant-edge collision: src0 held high across its own grant edge
        repeat (20) @(negedge clk);
        src_req = 4'b0001;
        wait_grant(5, at, vec);
        src_req = '0;
        check("coll_first", 32'(vec), 32'(4'b0001));
        prev_at = at;
        wait_grant(40, at, vec);
        check("coll_again", 32'(vec), 32'(4'b0001));
        check("coll_spacing", 32'(at - prev_at), 32'(SPACING));

        // Reset in the middle of SHOW
        repeat (20) @(negedge clk);
        src_value = {8'd0, 8'd0, 8'd42, 8'd0};
        src_req   = 4'b0010;
        @(negedge clk);
        src_req = '0;
        wait_grant(5, at, vec);
        repeat (10) @(negedge clk);
        check("mid_busy_pre", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  32'(busy),  32'(0));
        check("mid_rst_saida", 32'(saida), 32'(P000));
        check("mid_rst_sel",   32'(src_sel), 32'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_idle", 32'(busy), 32'(0));

        // Auto rotation with no requests
        do_reset();
        mode_auto = 1'b1;
        prev_at = 0;
        for (int j = 0; j < 5; j++) begin
            wait_busy_rise(40, at);
            check("auto_sel",   32'(src_sel),   32'(j % 4));
            check("auto_grant", 32'(src_grant), 32'(0));
            if (j > 0) check("auto_spacing", 32'(at - prev_at), 32'(SPACING));
            prev_at = at;
        end
        mode_auto = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            src_value = $urandom;
            if ($urandom_range(0, 3) == 0) src_value[7:0] = 8'd255;
            if ($urandom_range(0, 3) == 0) src_value[15:8] = 8'd100;
            if ($urandom_range(0, 3) == 0) src_value[31:24] = 8'd0;
            src_req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if (i % 200 == 0) mode_auto = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        src_req   = '0;
        mode_auto = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
